// File: rtl/dds_param_scheduler_pkg.sv
// Shared types and defaults for the timed DDS parameter scheduler.
package dds_param_scheduler_pkg;
  localparam int MAC_LATENCY_DEF = 4;
  localparam int TS_W_DEF        = 48;
  localparam int OFS_W           = 48;
  localparam int FREQ_W          = 48;
  localparam int PHASE_W         = 14;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // One held event; the time field is kept at MAC offset width since it only feeds mac_a.
  typedef struct packed {
    logic [OFS_W-1:0]   at;
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic               coherent;
  } evt_t;
endpackage

// File: rtl/dds_ts_counter.sv
// Free-running timestamp counter with run enable and synchronous clear.
module dds_ts_counter #(
  parameter int W = 48
)(
  input  logic         clk,
  input  logic         resetn,
  input  logic         run,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);
  always_comb begin
    count_next = count;
    if (clear)    count_next = '0;
    else if (run) count_next = count + W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count <= '0;
    else         count <= count_next;
  end
endmodule

// File: rtl/dds_param_scheduler.sv
// Holds one timed parameter event and loads it into the MAC operands so that it
// lands on the MAC output exactly at evt_time.
module dds_param_scheduler
  import dds_param_scheduler_pkg::*;
#(
  parameter int MAC_LATENCY = MAC_LATENCY_DEF,
  parameter int TS_W        = TS_W_DEF
)(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ts_run,
  input  logic                ts_clear,
  input  logic                evt_valid,
  output logic                evt_ready,
  input  logic [TS_W-1:0]     evt_time,
  input  logic [FREQ_W-1:0]   evt_freq,
  input  logic [PHASE_W-1:0]  evt_phase,
  input  logic                evt_coherent,
  input  logic                flush,
  output logic [OFS_W-1:0]    mac_a,
  output logic [FREQ_W-1:0]   mac_b,
  output logic [PHASE_W-1:0]  mac_c,
  output logic [TS_W-1:0]     mac_d,
  output logic                applied,
  output logic                late,
  output logic [15:0]         late_count
);
  localparam logic [TS_W-1:0] LAT = TS_W'(MAC_LATENCY);

  state_t          state, state_nxt;
  evt_t            held;
  logic [TS_W-1:0] target, d_next;
  logic            held_late, first, alive;
  logic            accept, load, load_late;

  dds_ts_counter #(.W(TS_W)) u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .run        (ts_run),
    .clear      (ts_clear),
    .count      (mac_d),
    .count_next (d_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = WAIT;
      WAIT:    if (flush || load) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Loading on the edge where the counter reaches target puts the operands
  // alongside mac_d == target; the late path fires only from the first WAIT cycle.
  always_comb begin
    evt_ready = alive && (state == IDLE);
    accept    = evt_valid && evt_ready && !flush;
    load      = 1'b0;
    load_late = 1'b0;
    if (state == WAIT && !flush) begin
      if (first && (held_late || mac_d >= target)) begin
        load      = 1'b1;
        load_late = 1'b1;
      end else if (d_next == target) begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alive      <= 1'b0;
      first      <= 1'b0;
      held       <= '0;
      target     <= '0;
      held_late  <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      mac_c      <= '0;
      applied    <= 1'b0;
      late       <= 1'b0;
      late_count <= '0;
    end else begin
      alive   <= 1'b1;
      first   <= accept;
      applied <= load;
      late    <= load_late;
      if (accept) begin
        held      <= '{at: OFS_W'(evt_time), freq: evt_freq, phase: evt_phase,
                       coherent: evt_coherent};
        target    <= evt_time - LAT;
        held_late <= (evt_time < LAT);
      end
      if (load) begin
        mac_b <= held.freq;
        mac_c <= held.phase;
        if (held.coherent) mac_a <= held.at;
      end
      if (load_late && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_dds_param_scheduler.sv
// Directed bench: table of timed events plus hand sequences for flush, stall and reset.
module tb_dds_param_scheduler;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ts_run = 1'b0, ts_clear = 1'b0;
  logic         evt_valid = 1'b0, evt_coherent = 1'b0, flush = 1'b0;
  logic         evt_ready, applied, late;
  logic [47:0]  evt_time = '0, evt_freq = '0;
  logic [13:0]  evt_phase = '0;
  logic [47:0]  mac_a, mac_b, mac_d;
  logic [13:0]  mac_c;
  logic [15:0]  late_count;

  int n_tests = 0;
  int n_fail  = 0;

  dds_param_scheduler #(.MAC_LATENCY(4), .TS_W(48)) dut (
    .clk(clk), .resetn(resetn), .ts_run(ts_run), .ts_clear(ts_clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
    .evt_freq(evt_freq), .evt_phase(evt_phase), .evt_coherent(evt_coherent),
    .flush(flush), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .applied(applied), .late(late), .late_count(late_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] t;
    logic [47:0] freq;
    logic [13:0] phase;
    logic        coh;
    logic [47:0] acc_at;
    logic [47:0] x_d;
    logic [47:0] x_a;
    logic        x_late;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counter();
    @(negedge clk);
    ts_clear = 1'b1;
    ts_run   = 1'b1;
    @(negedge clk);
    ts_clear = 1'b0;
  endtask

  task automatic wait_d(input logic [47:0] val);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (mac_d == val) break;
      @(negedge clk);
    end
    if (k == 2000) chk("wait_d timeout", 64'(mac_d), 64'(val));
  endtask

  task automatic offer(input logic [47:0] t, input logic [47:0] f,
                       input logic [13:0] p, input logic c);
    chk("ready before offer", 64'(evt_ready), 64'd1);
    evt_valid = 1'b1; evt_time = t; evt_freq = f; evt_phase = p; evt_coherent = c;
    @(negedge clk);
    evt_valid = 1'b0;
    chk("ready low while held", 64'(evt_ready), 64'd0);
  endtask

  task automatic wait_apply(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (applied) break;
      @(negedge clk);
    end
    chk({name, " applied seen"}, 64'(applied), 64'd1);
  endtask

  initial begin
    int saw;
    vecs[0] = '{t:100, freq:48'h1000, phase:14'h155, coh:1, acc_at:0,  x_d:96,  x_a:100, x_late:0, x_cnt:0};
    vecs[1] = '{t:150, freq:48'h2000, phase:14'h2AA, coh:0, acc_at:10, x_d:146, x_a:100, x_late:0, x_cnt:0};
    vecs[2] = '{t:10,  freq:48'h3000, phase:14'h001, coh:1, acc_at:50, x_d:52,  x_a:10,  x_late:1, x_cnt:1};
    vecs[3] = '{t:2,   freq:48'h4000, phase:14'h3FFF, coh:0, acc_at:0, x_d:2,   x_a:10,  x_late:1, x_cnt:2};
    vecs[4] = '{t:24,  freq:48'h4800, phase:14'h011, coh:1, acc_at:19, x_d:21,  x_a:24,  x_late:1, x_cnt:3};
    vecs[5] = '{t:25,  freq:48'h6000, phase:14'h0AB, coh:1, acc_at:19, x_d:21,  x_a:25,  x_late:0, x_cnt:3};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst evt_ready", 64'(evt_ready), 64'd0);
    chk("rst mac_a", 64'(mac_a), 64'd0);
    chk("rst mac_b", 64'(mac_b), 64'd0);
    chk("rst mac_c", 64'(mac_c), 64'd0);
    chk("rst mac_d", 64'(mac_d), 64'd0);
    chk("rst applied", 64'(applied), 64'd0);
    chk("rst late_count", 64'(late_count), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready after release", 64'(evt_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      clear_counter();
      wait_d(vecs[i].acc_at);
      offer(vecs[i].t, vecs[i].freq, vecs[i].phase, vecs[i].coh);
      wait_apply($sformatf("v%0d", i));
      chk($sformatf("v%0d mac_d", i), 64'(mac_d), 64'(vecs[i].x_d));
      chk($sformatf("v%0d mac_a", i), 64'(mac_a), 64'(vecs[i].x_a));
      chk($sformatf("v%0d mac_b", i), 64'(mac_b), 64'(vecs[i].freq));
      chk($sformatf("v%0d mac_c", i), 64'(mac_c), 64'(vecs[i].phase));
      chk($sformatf("v%0d late", i), 64'(late), 64'(vecs[i].x_late));
      chk($sformatf("v%0d late_count", i), 64'(late_count), 64'(vecs[i].x_cnt));
      @(negedge clk);
      chk($sformatf("v%0d applied pulse", i), 64'(applied), 64'd0);
      chk($sformatf("v%0d late pulse", i), 64'(late), 64'd0);
    end

    // flush in IDLE blocks acceptance
    evt_valid = 1'b1; flush = 1'b1; evt_time = 48'd1000; evt_freq = 48'hDEAD; evt_coherent = 1'b1;
    @(negedge clk);
    evt_valid = 1'b0; flush = 1'b0;
    chk("idle flush blocks accept", 64'(evt_ready), 64'd1);

    // flush while holding an event
    clear_counter();
    wait_d(140);
    offer(200, 48'h7000, 14'h3FF, 1'b1);
    wait_d(150);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ready after flush", 64'(evt_ready), 64'd1);
    saw = 0;
    for (int k = 0; k < 120; k++) begin
      if (applied) saw = 1;
      @(negedge clk);
    end
    chk("flush no apply", 64'(saw), 64'd0);
    chk("flush mac_a held", 64'(mac_a), 64'd25);
    chk("flush mac_b held", 64'(mac_b), 64'h6000);
    chk("flush mac_c held", 64'(mac_c), 64'h0AB);

    // stalled counter while waiting
    clear_counter();
    wait_d(240);
    offer(300, 48'h5000, 14'h123, 1'b1);
    wait_d(250);
    ts_run = 1'b0;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (applied) saw = 1;
    end
    chk("stall no apply", 64'(saw), 64'd0);
    chk("stall mac_d", 64'(mac_d), 64'd250);
    ts_run = 1'b1;
    wait_apply("stall");
    chk("stall mac_d at apply", 64'(mac_d), 64'd296);
    chk("stall late", 64'(late), 64'd0);
    chk("stall mac_a", 64'(mac_a), 64'd300);
    chk("stall mac_b", 64'(mac_b), 64'h5000);
    chk("stall mac_c", 64'(mac_c), 64'h123);

    // reset while holding an event
    clear_counter();
    wait_d(0);
    offer(500, 48'h8000, 14'h001, 1'b1);
    wait_d(30);
    resetn = 1'b0;
    #1;
    chk("wait rst evt_ready", 64'(evt_ready), 64'd0);
    chk("wait rst mac_a", 64'(mac_a), 64'd0);
    chk("wait rst mac_b", 64'(mac_b), 64'd0);
    chk("wait rst mac_c", 64'(mac_c), 64'd0);
    chk("wait rst mac_d", 64'(mac_d), 64'd0);
    chk("wait rst applied", 64'(applied), 64'd0);
    chk("wait rst late", 64'(late), 64'd0);
    chk("wait rst late_count", 64'(late_count), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready after wait rst", 64'(evt_ready), 64'd1);
    clear_counter();
    wait_d(0);
    offer(20, 48'h9000, 14'h002, 1'b1);
    wait_apply("post rst");
    chk("post rst mac_d", 64'(mac_d), 64'd16);
    chk("post rst mac_a", 64'(mac_a), 64'd20);
    chk("post rst mac_b", 64'(mac_b), 64'h9000);
    chk("post rst late", 64'(late), 64'd0);
    chk("post rst late_count", 64'(late_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
